sonar_ranger_mc: RTL and testbench
==================================

Name: sonar_ranger_mc

Overview:
Multi-channel HC-SR04 ranging controller. It round-robins over N_CH sensors: it issues a parametrised trigger pulse, times the echo width with a 2-flop synchronised input, and converts the width to centimetres with a prescaler. Each result (or timeout) is delivered on a valid/ready output to the downstream BCD/display path. It replaces the fixed single-channel trigger divider, trigger generator and echo counter chain.

Parameters:
N_CH, 2, number of sensors (1..8)
TRIG_CYCLES, 250, trigger high time in clk cycles (10 us at 25 MHz)
PERIOD_CYCLES, 1500000, cycles from one trigger rise to the next (60 ms)
TIMEOUT_CYCLES, 750000, max cycles from trigger fall until echo fall (30 ms)
CM_DIV, 1450, clk cycles per centimetre of echo (58 us at 25 MHz)
MAX_CM, 400, saturation value of dist_cm
DIST_W, 9, width of dist_cm
CH_W, 1, width of dist_ch; must satisfy CH_W = max(1, clog2(N_CH))

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  start/continue ranging cycles
echo  in  N_CH  raw asynchronous echo lines, one per sensor
trigger  out  N_CH  trigger lines; at most one bit high at any time
dist_cm  out  DIST_W  measured distance in cm; all ones on timeout
dist_ch  out  CH_W  channel index of the current result
dist_timeout  out  1  result is a timeout (no echo, or echo too long)
dist_valid  out  1  result available; held until accepted
dist_ready  in  1  downstream accepts the result when dist_valid && dist_ready
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE; trigger=0; dist_cm=0; dist_ch=0; dist_timeout=0; dist_valid=0; busy=0; channel pointer=0; all counters=0; synchroniser flops=0.
- echo passes through a 2-flop synchroniser per bit. Only the selected channel's synchronised bit (echo_s) is used. This adds 2 cycles of latency.
- A period counter clears on entry to TRIG and increments every cycle in every state until the next TRIG.
- IDLE: if enable=1, go to TRIG on the next cycle.
- TRIG: trigger[ch]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE. The timeout counter clears at that transition.
- WAIT_RISE: timeout counter increments. If echo_s=1, go to MEASURE; the cm counter and prescaler clear. If the timeout counter reaches TIMEOUT_CYCLES-1, go to REPORT with timeout=1.
- MEASURE:
  - The timeout counter keeps incrementing.
  - The prescaler counts 0..CM_DIV-1. On wrap, the cm counter increments, saturating at MAX_CM.
  - If echo_s=0, go to REPORT with dist = cm counter and timeout=0. A partial CM_DIV is truncated.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 first, go to REPORT with timeout=1.
- REPORT (one cycle):
  - Load dist_cm, dist_ch=ch and dist_timeout; set dist_valid=1.
  - On timeout, dist_cm = {DIST_W{1'b1}}.
  - Go to GAP.
- GAP:
  - Wait until the period counter reaches PERIOD_CYCLES-1 and dist_valid=0.
  - Then advance ch (ch = ch+1, wrapping N_CH-1 to 0).
  - Go to TRIG if enable=1, else IDLE.
  - If the result is still unaccepted when the period expires, stay in GAP. The next trigger is delayed; no result is ever overwritten or dropped.
- Handshake:
  - dist_valid falls in the cycle after dist_valid && dist_ready.
  - Outputs are stable while dist_valid=1 && dist_ready=0.
  - dist_ready may be tied high.
- enable=0 mid-measurement: the current measurement completes and reports, then the block returns to IDLE from GAP. enable is sampled only in IDLE and on GAP exit.
- Echo already high on entry to WAIT_RISE (stale echo): it is treated as a rise. Sensors must be spaced by PERIOD_CYCLES.
- Echo rise in the same cycle as timeout expiry: timeout wins.
- trigger is registered. At most one trigger bit is high at a time.
- reset in any state: immediately returns to the reset values. Any pending result is discarded.
- Widths: the cm counter is DIST_W bits. The period and timeout counters are sized clog2 of their parameters.

Test Plan:
Bench uses N_CH=2, TRIG_CYCLES=5, CM_DIV=10, MAX_CM=20, DIST_W=6, TIMEOUT_CYCLES=400, PERIOD_CYCLES=500.
1. Reset, enable=1, dist_ready=1, echo[0] high for 123 cycles, 20 cycles after trigger fall -> trigger[0] high exactly 5 cycles; dist_cm=12, dist_ch=0, dist_timeout=0, one dist_valid pulse.
2. Continue; echo[1] high for 57 cycles -> next trigger[1] rises exactly 500 cycles after the trigger[0] rise; dist_cm=5, dist_ch=1; trigger[0] stays 0.
3. No echo on channel 0 -> REPORT 400 cycles after trigger fall; dist_cm=63, dist_timeout=1; the block proceeds to channel 1.
4. Echo high 300 cycles -> dist_cm saturates at 20 (not 30), dist_timeout=0. Echo high 450 cycles -> timeout=1, dist_cm=63.
5. dist_ready=0 for 2000 cycles after a result -> dist_valid and outputs held constant, no trigger issued. Then dist_ready=1 -> dist_valid clears the next cycle; the next trigger rises within 2 cycles.
6. Drop enable during MEASURE -> the result still reports, busy falls after GAP, no further trigger. Assert reset during TRIG -> trigger=0 and busy=0 the next cycle; the channel pointer returns to 0.

Source files
------------

// File: rtl/sonar_ranger_mc.sv
// Multi-channel HC-SR04 ranging controller: round-robin trigger, echo timing, cm conversion,
// and valid/ready result delivery with timeout reporting.
module sonar_ranger_mc #(
  parameter int unsigned N_CH           = 2,
  parameter int unsigned TRIG_CYCLES    = 250,
  parameter int unsigned PERIOD_CYCLES  = 1500000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned CM_DIV         = 1450,
  parameter int unsigned MAX_CM         = 400,
  parameter int unsigned DIST_W         = 9,
  parameter int unsigned CH_W           = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_CH-1:0]   echo,
  output logic [N_CH-1:0]   trigger,
  output logic [DIST_W-1:0] dist_cm,
  output logic [CH_W-1:0]   dist_ch,
  output logic              dist_timeout,
  output logic              dist_valid,
  input  logic              dist_ready,
  output logic              busy
);

  localparam int unsigned PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TRG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam int unsigned PRE_W = (CM_DIV > 1) ? $clog2(CM_DIV) : 1;

  localparam logic [PER_W-1:0]  PER_MAX = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TRG_W-1:0]  TRG_MAX = TRG_W'(TRIG_CYCLES - 1);
  localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(CM_DIV - 1);
  localparam logic [DIST_W-1:0] CM_SAT  = DIST_W'(MAX_CM);
  localparam logic [CH_W-1:0]   CH_LAST = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StReport,
    StGap
  } state_e;

  state_e             state;
  logic [CH_W-1:0]    ch;
  logic [N_CH-1:0]    echo_q1;
  logic [N_CH-1:0]    echo_q2;
  logic [PER_W-1:0]   period_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [TRG_W-1:0]   trig_cnt;
  logic [PRE_W-1:0]   presc;
  logic [DIST_W-1:0]  cm_cnt;
  logic               tmo_flag;

  logic               echo_s;
  logic [CH_W-1:0]    ch_next;
  logic [N_CH-1:0]    ch_onehot;
  logic [N_CH-1:0]    ch_next_onehot;

  assign echo_s         = echo_q2[ch];
  assign ch_next        = (ch == CH_LAST) ? '0 : ch + 1'b1;
  assign ch_onehot      = N_CH'(1) << ch;
  assign ch_next_onehot = N_CH'(1) << ch_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      ch           <= '0;
      echo_q1      <= '0;
      echo_q2      <= '0;
      period_cnt   <= '0;
      tmo_cnt      <= '0;
      trig_cnt     <= '0;
      presc        <= '0;
      cm_cnt       <= '0;
      tmo_flag     <= 1'b0;
      trigger      <= '0;
      dist_cm      <= '0;
      dist_ch      <= '0;
      dist_timeout <= 1'b0;
      dist_valid   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      echo_q1 <= echo;
      echo_q2 <= echo_q1;

      // Saturate so a long IDLE or a stalled GAP cannot wrap the period count.
      if (period_cnt != PER_MAX) period_cnt <= period_cnt + 1'b1;

      if (dist_valid && dist_ready) dist_valid <= 1'b0;

      unique case (state)
        StIdle: begin
          if (enable) begin
            state      <= StTrig;
            trigger    <= ch_onehot;
            trig_cnt   <= '0;
            period_cnt <= '0;
            busy       <= 1'b1;
          end
        end

        StTrig: begin
          if (trig_cnt == TRG_MAX) begin
            state   <= StWaitRise;
            trigger <= '0;
            tmo_cnt <= '0;
          end else begin
            trig_cnt <= trig_cnt + 1'b1;
          end
        end

        StWaitRise: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // Timeout takes priority over a rise seen in the same cycle.
          if (tmo_cnt == TMO_MAX) begin
            state    <= StReport;
            tmo_flag <= 1'b1;
          end else if (echo_s) begin
            state  <= StMeasure;
            cm_cnt <= '0;
            presc  <= '0;
          end
        end

        StMeasure: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (presc == PRE_MAX) begin
            presc <= '0;
            if (cm_cnt != CM_SAT) cm_cnt <= cm_cnt + 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
          if (tmo_cnt == TMO_MAX) begin
            state    <= StReport;
            tmo_flag <= 1'b1;
          end else if (!echo_s) begin
            state    <= StReport;
            tmo_flag <= 1'b0;
          end
        end

        StReport: begin
          dist_cm      <= tmo_flag ? {DIST_W{1'b1}} : cm_cnt;
          dist_ch      <= ch;
          dist_timeout <= tmo_flag;
          dist_valid   <= 1'b1;
          state        <= StGap;
        end

        StGap: begin
          // An unaccepted result holds off the next trigger rather than being overwritten.
          if ((period_cnt == PER_MAX) && !dist_valid) begin
            ch <= ch_next;
            if (enable) begin
              state      <= StTrig;
              trigger    <= ch_next_onehot;
              trig_cnt   <= '0;
              period_cnt <= '0;
            end else begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state   <= StIdle;
          trigger <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_ranger_mc.sv
// Randomised self-checking bench for sonar_ranger_mc; expected results come from echo width
// arithmetic and the trigger/period timing rules.
module tb_sonar_ranger_mc;

  localparam int unsigned N_CH           = 2;
  localparam int unsigned TRIG_CYCLES    = 5;
  localparam int unsigned PERIOD_CYCLES  = 500;
  localparam int unsigned TIMEOUT_CYCLES = 400;
  localparam int unsigned CM_DIV         = 10;
  localparam int unsigned MAX_CM         = 20;
  localparam int unsigned DIST_W         = 6;
  localparam int unsigned CH_W           = 1;
  localparam int          TMO_CM         = (1 << DIST_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [N_CH-1:0]   echo = '0;
  logic [N_CH-1:0]   trigger;
  logic [DIST_W-1:0] dist_cm;
  logic [CH_W-1:0]   dist_ch;
  logic              dist_timeout;
  logic              dist_valid;
  logic              dist_ready = 1'b1;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int multi_trig = 0;
  int exp_ch = 0;
  int last_rise = -1;

  sonar_ranger_mc #(
    .N_CH          (N_CH),
    .TRIG_CYCLES   (TRIG_CYCLES),
    .PERIOD_CYCLES (PERIOD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CM_DIV        (CM_DIV),
    .MAX_CM        (MAX_CM),
    .DIST_W        (DIST_W),
    .CH_W          (CH_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .echo        (echo),
    .trigger     (trigger),
    .dist_cm     (dist_cm),
    .dist_ch     (dist_ch),
    .dist_timeout(dist_timeout),
    .dist_valid  (dist_valid),
    .dist_ready  (dist_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!$onehot0(trigger)) multi_trig <= multi_trig + 1;
  end

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Whole centimetres in an echo of w cycles, saturated.
  function automatic int model_cm(input int w);
    int cm;
    cm = w / CM_DIV;
    if (cm > MAX_CM) cm = MAX_CM;
    return cm;
  endfunction

  task automatic wait_trig(input int c, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (trigger[c] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // One ranging cycle on the expected channel: echo rises d cycles after trigger fall and
  // lasts w cycles (w=0: no echo). Widths are kept off CM_DIV multiples and away from the
  // timeout boundary so the expected result does not depend on edge-cycle ordering.
  task automatic run_meas(input int d, input int w, input bit chk_period, input int drop_at,
                          input string tag, output int o_cm, output bit o_tmo, output int o_ch);
    int c, hi, rise, jv, nvalid, exp_cm;
    bit ok, got, exp_tmo;
    logic [DIST_W-1:0] cm_s;
    logic [CH_W-1:0]   ch_s;
    logic              tmo_s;
    c       = exp_ch;
    exp_tmo = (w == 0) || (d + w >= int'(TIMEOUT_CYCLES));
    exp_cm  = exp_tmo ? TMO_CM : model_cm(w);
    o_cm    = exp_cm;
    o_tmo   = exp_tmo;
    o_ch    = c;
    exp_ch  = (exp_ch + 1) % N_CH;

    wait_trig(c, 3 * PERIOD_CYCLES, ok);
    vectors++;
    if (!ok) begin
      $display("FAIL %s trigger_rise: trigger[%0d] never rose, required within %0d cycles",
               tag, c, 3 * PERIOD_CYCLES);
      miscompares++;
      return;
    end
    rise = cyc;
    if (chk_period) begin
      vectors++;
      if (rise - last_rise !== int'(PERIOD_CYCLES)) begin
        $display("FAIL %s trigger_period: rise spacing %0d, required %0d", tag,
                 rise - last_rise, PERIOD_CYCLES);
        miscompares++;
      end
    end
    last_rise = rise;

    hi = 0;
    while (trigger[c] === 1'b1 && hi < 100) begin
      hi++;
      tick();
    end
    vectors++;
    if (hi !== int'(TRIG_CYCLES)) begin
      $display("FAIL %s trigger_width: high %0d cycles, required %0d", tag, hi, TRIG_CYCLES);
      miscompares++;
    end

    got = 1'b0;
    nvalid = 0;
    jv = -1;
    cm_s = '0;
    ch_s = '0;
    tmo_s = 1'b0;
    for (int j = 0; j < 1500; j++) begin
      if (j == drop_at) enable = 1'b0;
      echo[c] = (j >= d) && (j < d + w);
      if (dist_valid === 1'b1) begin
        if (!got) begin
          got = 1'b1;
          jv = j;
          cm_s = dist_cm;
          ch_s = dist_ch;
          tmo_s = dist_timeout;
        end
        nvalid++;
      end
      if (got && j >= d + w) break;
      tick();
    end
    echo[c] = 1'b0;

    vectors++;
    if (!got) begin
      $display("FAIL %s result_valid: dist_valid never rose, required one result", tag);
      miscompares++;
      return;
    end
    vectors++;
    if (cm_s !== DIST_W'(exp_cm)) begin
      $display("FAIL %s dist_cm: got %0d, required %0d (w=%0d d=%0d)", tag, cm_s, exp_cm, w, d);
      miscompares++;
    end
    vectors++;
    if (ch_s !== CH_W'(c)) begin
      $display("FAIL %s dist_ch: got %0d, required %0d", tag, ch_s, c);
      miscompares++;
    end
    vectors++;
    if (tmo_s !== exp_tmo) begin
      $display("FAIL %s dist_timeout: got %0b, required %0b", tag, tmo_s, exp_tmo);
      miscompares++;
    end
    // Timeout lands in the one-cycle report state; its registered result shows a cycle later.
    if (w == 0) begin
      vectors++;
      if (jv !== int'(TIMEOUT_CYCLES) + 1) begin
        $display("FAIL %s timeout_latency: valid %0d cycles after trigger fall, required %0d",
                 tag, jv, TIMEOUT_CYCLES + 1);
        miscompares++;
      end
    end
    if (dist_ready) begin
      tick();
      vectors++;
      if (nvalid !== 1 || dist_valid !== 1'b0) begin
        $display("FAIL %s valid_pulse: %0d cycles then valid=%0b, required 1 cycle then 0",
                 tag, nvalid, dist_valid);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) tick();
    vectors++;
    if (trigger !== '0 || busy !== 1'b0) begin
      $display("FAIL reset_ctrl: trigger=%b busy=%b, required 0 0", trigger, busy);
      miscompares++;
    end
    vectors++;
    if (dist_cm !== '0 || dist_ch !== '0 || dist_timeout !== 1'b0 || dist_valid !== 1'b0) begin
      $display("FAIL reset_result: cm=%0d ch=%0d tmo=%b valid=%b, required all 0",
               dist_cm, dist_ch, dist_timeout, dist_valid);
      miscompares++;
    end
    reset = 1'b0;
    repeat (10) tick();
    vectors++;
    if (trigger !== '0 || busy !== 1'b0) begin
      $display("FAIL idle_disabled: trigger=%b busy=%b, required 0 0", trigger, busy);
      miscompares++;
    end
  endtask

  task automatic test_basic();
    int cm, ch;
    bit tmo;
    enable = 1'b1;
    dist_ready = 1'b1;
    run_meas(20, 123, 1'b0, -1, "basic_ch0", cm, tmo, ch);
    run_meas(20, 57, 1'b1, -1, "basic_ch1", cm, tmo, ch);
  endtask

  task automatic test_timeout();
    int cm, ch;
    bit tmo;
    run_meas(0, 0, 1'b1, -1, "no_echo", cm, tmo, ch);
    run_meas(20, 303, 1'b1, -1, "saturate", cm, tmo, ch);
    run_meas(20, 450, 1'b1, -1, "long_echo", cm, tmo, ch);
  endtask

  task automatic test_random();
    int d, w, cm, ch;
    bit tmo;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(3))
        0: begin
          d = $urandom_range(3, 20);
          w = $urandom_range(420, 455);
        end
        1: begin
          d = 0;
          w = 0;
        end
        default: begin
          d = $urandom_range(3, 40);
          do w = $urandom_range(11, 300); while (w % CM_DIV == 0);
        end
      endcase
      run_meas(d, w, 1'b1, -1, "random", cm, tmo, ch);
    end
  endtask

  task automatic test_back_pressure();
    int w, cm, ch, bad, trig_seen;
    bit tmo, seen;
    do w = $urandom_range(11, 150); while (w % CM_DIV == 0);
    dist_ready = 1'b0;
    run_meas(15, w, 1'b1, -1, "stall", cm, tmo, ch);
    bad = 0;
    trig_seen = 0;
    repeat (2000) begin
      tick();
      if (dist_valid !== 1'b1 || dist_cm !== DIST_W'(cm) || dist_ch !== CH_W'(ch) ||
          dist_timeout !== tmo) bad++;
      if (trigger !== '0) trig_seen++;
    end
    vectors++;
    if (bad !== 0) begin
      $display("FAIL stall_hold: %0d cycles with changed result, required 0", bad);
      miscompares++;
    end
    vectors++;
    if (trig_seen !== 0) begin
      $display("FAIL stall_no_trigger: %0d trigger cycles, required 0", trig_seen);
      miscompares++;
    end
    dist_ready = 1'b1;
    tick();
    vectors++;
    if (dist_valid !== 1'b0) begin
      $display("FAIL stall_release: dist_valid=%b, required 0", dist_valid);
      miscompares++;
    end
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (trigger[exp_ch] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    vectors++;
    if (!seen) begin
      $display("FAIL stall_retrigger: trigger[%0d] low, required high within 2 cycles", exp_ch);
      miscompares++;
    end
    run_meas(25, 88, 1'b0, -1, "after_stall", cm, tmo, ch);
  endtask

  task automatic test_enable_drop();
    int cm, ch, trig_seen;
    bit tmo, idle;
    run_meas(20, 105, 1'b1, 60, "enable_drop", cm, tmo, ch);
    idle = 1'b0;
    for (int i = 0; i < int'(PERIOD_CYCLES) + 20; i++) begin
      if (busy === 1'b0) begin
        idle = 1'b1;
        break;
      end
      tick();
    end
    vectors++;
    if (!idle) begin
      $display("FAIL drop_busy: busy still high, required low after gap");
      miscompares++;
    end
    trig_seen = 0;
    repeat (700) begin
      tick();
      if (trigger !== '0) trig_seen++;
    end
    vectors++;
    if (trig_seen !== 0) begin
      $display("FAIL drop_no_trigger: %0d trigger cycles, required 0", trig_seen);
      miscompares++;
    end
  endtask

  task automatic test_reset_in_trig();
    int cm, ch;
    bit tmo, ok;
    enable = 1'b1;
    if (exp_ch == 0) run_meas(10, 55, 1'b0, -1, "pre_reset", cm, tmo, ch);
    wait_trig(1, 3 * PERIOD_CYCLES, ok);
    vectors++;
    if (!ok) begin
      $display("FAIL reset_setup: trigger[1] never rose, required a rise");
      miscompares++;
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (trigger !== '0 || busy !== 1'b0) begin
      $display("FAIL reset_in_trig: trigger=%b busy=%b, required 0 0", trigger, busy);
      miscompares++;
    end
    reset = 1'b0;
    exp_ch = 0;
    wait_trig(0, 10, ok);
    vectors++;
    if (!ok || trigger[1] !== 1'b0) begin
      $display("FAIL reset_channel: trigger=%b, required channel 0 only", trigger);
      miscompares++;
    end
  endtask

  task automatic test_onehot();
    vectors++;
    if (multi_trig !== 0) begin
      $display("FAIL trigger_onehot: %0d cycles with several triggers, required 0", multi_trig);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_random();
    test_back_pressure();
    test_enable_drop();
    test_reset_in_trig();
    test_onehot();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
